// File: rtl/shift_pattern_tx.sv
// shift_pattern_tx: serial pattern transmitter.
// Loads a WIDTH-bit pattern and shifts it out MSB-first, one bit per tick_en,
// sending the frame (repeat_val+1) times back-to-back, then one TAIL tick.
// Optional build macro: SHIFT_PATTERN_TX_PARITY_EN adds one even-parity bit
// (PAR state) after the data bits of every frame.
module shift_pattern_tx #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned REPEAT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_en,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [WIDTH-1:0]    pattern,
    input  logic [REPEAT_W-1:0] repeat_val,
    input  logic                abort,
    output logic                d_out,
    output logic                d_valid,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    cur_pattern
);

    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        TAIL  = 2'd3
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    shreg;
    logic [BIT_W-1:0]    bit_cnt;
    logic [REPEAT_W-1:0] frame_cnt;

    // Transmit FSM with registered outputs; abort overrides everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            frame_cnt   <= '0;
            cur_pattern <= '0;
            d_out       <= 1'b0;
            d_valid     <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            load_ready  <= 1'b1;
        end else begin
            d_valid <= 1'b0;
            done    <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                d_out      <= 1'b0;
                busy       <= 1'b0;
                load_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        // Accept cycle ignores tick_en; first bit leaves on the next tick.
                        if (load_valid) begin
                            shreg       <= pattern;
                            cur_pattern <= pattern;
                            frame_cnt   <= repeat_val;
                            bit_cnt     <= '0;
                            state       <= SHIFT;
                            busy        <= 1'b1;
                            load_ready  <= 1'b0;
                        end
                    end
                    SHIFT: begin
                        if (tick_en) begin
                            d_out   <= shreg[WIDTH-1];
                            shreg   <= shreg << 1;
                            d_valid <= 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
`ifdef SHIFT_PATTERN_TX_PARITY_EN
                                state <= PAR;
`else
                                if (frame_cnt != '0) begin
                                    frame_cnt <= frame_cnt - REPEAT_W'(1);
                                    shreg     <= cur_pattern;
                                end else begin
                                    state <= TAIL;
                                end
`endif
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                    end
`ifdef SHIFT_PATTERN_TX_PARITY_EN
                    PAR: begin
                        // Even parity bit, then either the next frame or the tail.
                        if (tick_en) begin
                            d_out   <= ^cur_pattern;
                            d_valid <= 1'b1;
                            if (frame_cnt != '0) begin
                                frame_cnt <= frame_cnt - REPEAT_W'(1);
                                shreg     <= cur_pattern;
                                state     <= SHIFT;
                            end else begin
                                state <= TAIL;
                            end
                        end
                    end
`endif
                    TAIL: begin
                        // Last bit stays up one full tick period before returning low.
                        if (tick_en) begin
                            d_out      <= 1'b0;
                            done       <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                            load_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_pattern_tx.sv
// tb_shift_pattern_tx: directed bench for shift_pattern_tx (WIDTH=4, REPEAT_W=4).
module tb_shift_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_en;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] pattern;
    logic [3:0] repeat_val;
    logic       abort;
    logic       d_out;
    logic       d_valid;
    logic       busy;
    logic       done;
    logic [3:0] cur_pattern;

    int errors = 0;
    int checks = 0;
    int dv_cnt = 0;
    int done_cnt = 0;

`ifdef SHIFT_PATTERN_TX_PARITY_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    shift_pattern_tx #(.WIDTH(4), .REPEAT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_en    (tick_en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .pattern    (pattern),
        .repeat_val (repeat_val),
        .abort      (abort),
        .d_out      (d_out),
        .d_valid    (d_valid),
        .busy       (busy),
        .done       (done),
        .cur_pattern(cur_pattern)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the clock edge following each registered pulse.
    always @(posedge clk) begin
        if (d_valid) dv_cnt <= dv_cnt + 1;
        if (done)    done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One tick_en strobe; returns at the negedge after the tick edge.
    task automatic do_tick(input logic with_abort);
        tick_en = 1'b1;
        abort   = with_abort;
        @(posedge clk);
        @(negedge clk);
        tick_en = 1'b0;
        abort   = 1'b0;
    endtask

    // Seven idle cycles between ticks; optionally attempts a load while busy.
    task automatic gap(input logic poke, input logic [3:0] held);
        for (int c = 0; c < 7; c++) begin
            if (poke && c == 1) begin
                load_valid = 1'b1;
                pattern    = 4'b1111;
            end
            if (poke && c == 2) begin
                check("ready_while_busy", 32'(load_ready), 32'd0);
                check("cur_pat_while_busy", 32'(cur_pattern), 32'(held));
                load_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [3:0] pat, input logic [3:0] rep);
        pattern    = pat;
        repeat_val = rep;
        load_valid = 1'b1;
        tick_en    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        tick_en    = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_ready", 32'(load_ready), 32'd0);
        check("accept_dout", 32'(d_out), 32'd0);
        check("accept_cur_pat", 32'(cur_pattern), 32'(pat));
    endtask

    // Full transmission; exp_ticks is the hand-computed total including TAIL.
    task automatic run_frames(input logic [3:0] pat, input logic [3:0] rep,
                              input int exp_ticks, input logic poke);
        int dv0;
        int dn0;
        int pos;
        logic expb;
        do_load(pat, rep);
        dv0 = dv_cnt;
        dn0 = done_cnt;
        for (int t = 1; t < exp_ticks; t++) begin
            gap(poke && t == 3, pat);
            pos  = (t - 1) % FRAME_LEN;
            expb = (pos < 4) ? pat[3 - pos] : ^pat;
            do_tick(1'b0);
            check($sformatf("bit%0d", t), 32'(d_out), 32'(expb));
            check($sformatf("dvalid%0d", t), 32'(d_valid), 32'd1);
        end
        gap(1'b0, pat);
        check("pre_tail_busy", 32'(busy), 32'd1);
        check("pre_tail_dout_hold", 32'(d_out), 32'(FRAME_LEN == 5 ? ^pat : pat[0]));
        do_tick(1'b0);
        check("tail_dout", 32'(d_out), 32'd0);
        check("tail_done", 32'(done), 32'd1);
        check("tail_dvalid", 32'(d_valid), 32'd0);
        check("tail_busy", 32'(busy), 32'd0);
        check("tail_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        check("done_pulse_end", 32'(done), 32'd0);
        check("dvalid_count", 32'(dv_cnt - dv0), 32'(exp_ticks - 1));
        check("done_count", 32'(done_cnt - dn0), 32'd1);
    endtask

    initial begin
        int dn0;
        rst        = 1'b1;
        tick_en    = 1'b0;
        load_valid = 1'b0;
        pattern    = 4'h0;
        repeat_val = 4'h0;
        abort      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(load_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dout", 32'(d_out), 32'd0);
        check("rst_cur_pat", 32'(cur_pattern), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single frame 0110.
        run_frames(4'b0110, 4'd0, FRAME_LEN + 1, 1'b0);
        // Three frames back-to-back with a load attempt while busy.
        run_frames(4'b0110, 4'd2, 3 * FRAME_LEN + 1, 1'b1);

        // Abort coinciding with the tick of bit 2.
        do_load(4'b0110, 4'd0);
        dn0 = done_cnt;
        gap(1'b0, 4'b0110);
        do_tick(1'b0);
        check("abort_bit1", 32'(d_out), 32'd0);
        gap(1'b0, 4'b0110);
        do_tick(1'b1);
        check("abort_dout", 32'(d_out), 32'd0);
        check("abort_dvalid", 32'(d_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(load_ready), 32'd1);
        check("abort_cur_pat", 32'(cur_pattern), 32'b0110);
        for (int k = 0; k < 3; k++) begin
            gap(1'b0, 4'b0110);
            do_tick(1'b0);
        end
        check("abort_idle_dout", 32'(d_out), 32'd0);
        check("abort_no_done", 32'(done_cnt - dn0), 32'd0);

        // Asynchronous reset mid-frame, then a clean transmission.
        do_load(4'b1011, 4'd1);
        gap(1'b0, 4'b1011);
        do_tick(1'b0);
        gap(1'b0, 4'b1011);
        do_tick(1'b0);
        check("pre_rst_dout", 32'(d_out), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_ready", 32'(load_ready), 32'd1);
        check("async_rst_cur_pat", 32'(cur_pattern), 32'd0);
        check("async_rst_dout", 32'(d_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frames(4'b1011, 4'd0, FRAME_LEN + 1, 1'b0);

        // Odd-weight pattern: parity bit 1 when enabled.
        run_frames(4'b0111, 4'd0, FRAME_LEN + 1, 1'b0);
        // Maximum repeat: 16 frames.
        run_frames(4'b1001, 4'd15, 16 * FRAME_LEN + 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
